// File: rtl/gate_fill_ctrl_pkg.sv
// Shared types and constants for the gated SRAM-fill controller.
// Holds the FSM state encoding and the wake-timeout counter sizing.
package gate_fill_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAKE  = 3'd1,
        ST_FILL  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int WAKE_TIMEOUT_DEF = 15;

    // The counter only has to reach timeout-1, so clog2(timeout) bits suffice.
    function automatic int tmo_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    localparam int TMO_W_DEF = (WAKE_TIMEOUT_DEF > 1) ? $clog2(WAKE_TIMEOUT_DEF) : 1;

endpackage

// File: rtl/gate_fill_ctrl.sv
// Initiator-side controller for the gated SRAM-fill domain: wakes the gate,
// streams a job of len words into SRAM writes, shuts the gate down, reports done.
module gate_fill_ctrl
    import gate_fill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int WAKE_TIMEOUT = WAKE_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  clk_en_o,
    output logic                  clk_end_o,
    input  logic                  start_in_i,
    input  logic                  gate_on_i,
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  data_ready_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o
);

    localparam int              TMO_W    = tmo_width(WAKE_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAKE_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   len_q,   len_d;
    logic [ADDR_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [TMO_W-1:0]        tmo_q,   tmo_d;
    logic                    err_q,   err_d;
    logic                    we_q,    we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    hs_s;

    // Next-state, counter and SRAM write-register computation.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hs_s    = data_valid_i && (state_q == ST_FILL);

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (len_i != {ADDR_WIDTH{1'b0}}) begin
                        len_d   = len_i;
                        cnt_d   = {ADDR_WIDTH{1'b0}};
                        tmo_d   = {TMO_W{1'b0}};
                        err_d   = 1'b0;
                        state_d = ST_WAKE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAKE: begin
                // A start arriving on the timeout cycle still wins.
                if (start_in_i) begin
                    state_d = ST_FILL;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    tmo_d   = tmo_q + TMO_W'(1);
                end
            end
            ST_FILL: begin
                if (hs_s) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = data_i;
                    cnt_d   = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == (len_q - ADDR_WIDTH'(1))) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FLUSH: begin
                state_d = ST_STOP;
            end
            ST_STOP: begin
                if (!gate_on_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= {ADDR_WIDTH{1'b0}};
            cnt_q   <= {ADDR_WIDTH{1'b0}};
            tmo_q   <= {TMO_W{1'b0}};
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Control outputs are pure decodes of the state flop, so they never glitch
    // on inputs and clk_en/clk_end are mutually exclusive by construction.
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = (state_q == ST_DONE) && err_q;
    assign clk_en_o     = (state_q == ST_WAKE);
    assign clk_end_o    = (state_q == ST_STOP);
    assign data_ready_o = (state_q == ST_FILL);
    assign sram_we_o    = we_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

endmodule
